// File: rtl/sm_seq_checker.sv
// rtl/sm_seq_checker.sv - lock/error monitor for the 4-state sequencer stream
// Optional control-bit check on transitions out of state 1: SM_SEQ_CHECK_CONTROL_EN
module sm_seq_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       y_in,
  input  logic             y_valid,
  input  logic             control_in,
  input  logic             clr_sticky,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] loop_count,
  output logic [CNT_W-1:0] skip_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic [1:0] prev_y;
  logic       prev_ctl;
  logic [3:0] acq_cnt;
  logic       legal;
  logic       is_loop;
  logic       is_skip;

  always_comb begin
    legal = 1'b0;
    case (prev_y)
      2'd0: legal = (y_in == 2'd1);
`ifdef SM_SEQ_CHECK_CONTROL_EN
      // the control bit sampled with the 1 selects the only legal successor
      2'd1: legal = prev_ctl ? (y_in == 2'd3) : (y_in == 2'd2);
`else
      2'd1: legal = (y_in == 2'd2) || (y_in == 2'd3);
`endif
      2'd2: legal = (y_in == 2'd3);
      default: legal = (y_in == 2'd0);
    endcase
  end

`ifndef SM_SEQ_CHECK_CONTROL_EN
  logic unused_ctl;
  assign unused_ctl = prev_ctl ^ control_in;
`endif

  assign is_loop = (prev_y == 2'd3) && (y_in == 2'd0);
  assign is_skip = (prev_y == 2'd1) && (y_in == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      prev_y     <= 2'd0;
      prev_ctl   <= 1'b0;
      acq_cnt    <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      loop_count <= '0;
      skip_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_sticky) begin
        err_sticky <= 1'b0;
      end
      if (y_valid) begin
        prev_y   <= y_in;
        prev_ctl <= control_in;
        case (state)
          HUNT: begin
            if (y_in == 2'd0) begin
              state   <= ACQ;
              acq_cnt <= 4'd0;
            end
          end
          ACQ: begin
            if (legal) begin
              if (acq_cnt + 4'd1 == LOCK_TGT) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                acq_cnt <= 4'd0;
              end else begin
                acq_cnt <= acq_cnt + 4'd1;
              end
            end else if (y_in == 2'd0) begin
              acq_cnt <= 4'd0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            if (legal) begin
              if (is_loop && loop_count != CNT_MAX) begin
                loop_count <= loop_count + 1'b1;
              end
              if (is_skip && skip_count != CNT_MAX) begin
                skip_count <= skip_count + 1'b1;
              end
            end else begin
              // written after the clear above so a concurrent error keeps sticky set
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
              end
              locked  <= 1'b0;
              acq_cnt <= 4'd0;
              state   <= (y_in == 2'd0) ? ACQ : HUNT;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_seq_checker.sv
// tb/tb_sm_seq_checker.sv - directed vector bench for sm_seq_checker
module tb_sm_seq_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] y_in = 2'd0;
  logic       y_valid = 1'b0;
  logic       control_in = 1'b0;
  logic       clr_sticky = 1'b0;

  logic       locked, err_pulse, err_sticky;
  logic [7:0] err_count, loop_count, skip_count;
  logic       locked2, err_pulse2, err_sticky2;
  logic [1:0] err_count2, loop_count2, skip_count2;

  always #5 clk = ~clk;

  sm_seq_checker #(.CNT_W(8), .LOCK_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .y_in(y_in), .y_valid(y_valid),
    .control_in(control_in), .clr_sticky(clr_sticky),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .loop_count(loop_count), .skip_count(skip_count)
  );

  sm_seq_checker #(.CNT_W(2), .LOCK_LEN(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .y_in(y_in), .y_valid(y_valid),
    .control_in(control_in), .clr_sticky(clr_sticky),
    .locked(locked2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
    .err_count(err_count2), .loop_count(loop_count2), .skip_count(skip_count2)
  );

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic       c;
    logic       clr;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl[$];
  int applied = 0;
  int miscompares = 0;

  function automatic logic [26:0] pk(input logic l, input logic p, input logic s,
                                     input int e, input int lp, input int sk);
    return {l, p, s, 8'(e), 8'(lp), 8'(sk)};
  endfunction

  function automatic logic [26:0] obs1();
    return {locked, err_pulse, err_sticky, err_count, loop_count, skip_count};
  endfunction

  function automatic logic [26:0] obs2();
    return {locked2, err_pulse2, err_sticky2, 6'd0, err_count2,
            6'd0, loop_count2, 6'd0, skip_count2};
  endfunction

  task automatic add(input logic v, input logic [1:0] y, input logic c, input logic clr,
                     input logic l, input logic p, input logic s,
                     input int e, input int lp, input int sk);
    vec_t r;
    r.v = v; r.y = y; r.c = c; r.clr = clr;
    r.exp = pk(l, p, s, e, lp, sk);
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got l/p/s=%b e=%0d lp=%0d sk=%0d, want l/p/s=%b e=%0d lp=%0d sk=%0d",
               name, act[26:24], act[23:16], act[15:8], act[7:0],
               exp[26:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] y, input logic c, input logic clr);
    y_valid = v; y_in = y; control_in = c; clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // lock: 0,1,2,3,0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // three short loops 0,1,3,0 with control=1 at the 1
    for (int k = 1; k <= 3; k++) begin
      add(1, 1, 1, 0, 1, 0, 0, 0, k-1, k-1);
      add(1, 3, 0, 0, 1, 0, 0, 0, k-1, k);
      add(1, 0, 0, 0, 1, 0, 0, 0, k, k);
    end
    // long loop with gaps of 1 and 7 idle cycles carrying junk y
    add(1, 1, 0, 0, 1, 0, 0, 0, 3, 3);
    add(0, 3, 1, 0, 1, 0, 0, 0, 3, 3);
    add(1, 2, 0, 0, 1, 0, 0, 0, 3, 3);
    add(0, 0, 0, 0, 1, 0, 0, 0, 3, 3);
    add(0, 1, 1, 0, 1, 0, 0, 0, 3, 3);
    add(0, 2, 0, 0, 1, 0, 0, 0, 3, 3);
    add(0, 3, 1, 0, 1, 0, 0, 0, 3, 3);
    add(0, 0, 0, 0, 1, 0, 0, 0, 3, 3);
    add(0, 0, 1, 0, 1, 0, 0, 0, 3, 3);
    add(0, 2, 0, 0, 1, 0, 0, 0, 3, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 3, 3);
    add(1, 0, 0, 0, 1, 0, 0, 0, 4, 3);
    // 0->2 in LOCKED: error, drop to HUNT
    add(1, 2, 0, 0, 0, 1, 1, 1, 4, 3);
    add(1, 3, 0, 0, 0, 0, 1, 1, 4, 3);
    // reacquire, with a 0->0 self-loop restarting ACQ
    add(1, 0, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 0, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 1, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 2, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 3, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 0, 0, 0, 1, 0, 1, 1, 4, 3);
    // 1 with control=1 followed by 2
    add(1, 1, 1, 0, 1, 0, 1, 1, 4, 3);
`ifdef SM_SEQ_CHECK_CONTROL_EN
    add(1, 2, 0, 0, 0, 1, 1, 2, 4, 3);
    add(1, 3, 0, 0, 0, 0, 1, 2, 4, 3);
    add(1, 0, 0, 0, 0, 0, 1, 2, 4, 3);
    add(0, 0, 0, 1, 0, 0, 0, 2, 4, 3);
`else
    add(1, 2, 0, 0, 1, 0, 1, 1, 4, 3);
    add(1, 3, 0, 0, 1, 0, 1, 1, 4, 3);
    add(1, 0, 0, 0, 1, 0, 1, 1, 5, 3);
    add(0, 0, 0, 1, 1, 0, 0, 1, 5, 3);
`endif

    @(posedge clk);
    #1;
    check("reset_state", obs1(), pk(0, 0, 0, 0, 0, 0));
    check("reset_state_w2", obs2(), pk(0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].y, tbl[i].c, tbl[i].clr);
      check($sformatf("vec%0d", i), obs1(), tbl[i].exp);
    end

    // saturation on the CNT_W=2 instance, sticky set-wins and clear
    step(0, 0, 0, 0);
    reset_n = 1'b0;
    step(0, 0, 0, 0);
    check("sat_reset", obs2(), pk(0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(1, 0, 0, 0);
    check("sat_lock", obs2(), pk(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, (i == 5));
      check($sformatf("sat_err%0d", i), obs1(), pk(0, 1, 1, i, 0, 0));
      check($sformatf("sat_err%0d_w2", i), obs2(), pk(0, 1, 1, (i > 3) ? 3 : i, 0, 0));
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      step(1, 3, 0, 0);
      step(1, 0, 0, 0);
      check($sformatf("sat_relock%0d_w2", i), obs2(), pk(1, 0, 1, (i > 3) ? 3 : i, 0, 0));
    end
    step(0, 2, 0, 1);
    check("clr_sticky", obs1(), pk(1, 0, 0, 5, 0, 0));
    check("clr_sticky_w2", obs2(), pk(1, 0, 0, 3, 0, 0));

    // async reset mid-loop, checked well before the next clock edge
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    check("midloop_pre", obs1(), pk(1, 0, 0, 5, 0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs1(), pk(0, 0, 0, 0, 0, 0));
    check("async_reset_w2", obs2(), pk(0, 0, 0, 0, 0, 0));
    step(1, 3, 0, 0);
    check("reset_held", obs1(), pk(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
